// File: rtl/proc_trace_buffer.sv
// Writeback/store trace capture unit.
// Register-file writes and data-memory writes are timestamped with a
// free-running cycle count and pushed into a show-ahead FIFO for a host
// to drain. A PC trigger can gate the start of capture, and a cycle limit
// ends it.
module proc_trace_buffer #(
  parameter int DEPTH       = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int PC_WIDTH    = 12,
  parameter int ADDR_WIDTH  = 12,
  parameter int CNT_WIDTH   = 16,
  parameter int CYCLE_LIMIT = 100
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ctrl_writeEnable,
  input  logic [4:0]                ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0]     data_writeReg,
  input  logic                      wren,
  input  logic [ADDR_WIDTH-1:0]     address_dmem,
  input  logic [DATA_WIDTH-1:0]     data,
  input  logic [PC_WIDTH-1:0]       pc,
  input  logic [1:0]                capture_mode,
  input  logic                      trig_en,
  input  logic [PC_WIDTH-1:0]       trig_pc,
  input  logic                      rd_en,
  output logic                      rd_valid,
  output logic                      rd_type,
  output logic [CNT_WIDTH-1:0]      rd_cycle,
  output logic [PC_WIDTH-1:0]       rd_pc,
  output logic [ADDR_WIDTH-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic [7:0]                drop_count,
  output logic [CNT_WIDTH-1:0]      cycle,
  output logic                      done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_ARMED, ST_CAPTURE, ST_DONE} state_t;

  state_t state, state_next;

  logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_p1;

  logic                  mem_type  [DEPTH];
  logic [CNT_WIDTH-1:0]  mem_cycle [DEPTH];
  logic [PC_WIDTH-1:0]   mem_pc    [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_addr  [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data  [DEPTH];

  logic                  trig_hit, at_last, below_limit, cap;
  logic                  reg_ev, mem_ev, push_reg, push_mem, push0, push1;
  logic                  full, one_free, pop;
  logic [1:0]            n_push, n_drop;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [8:0]            drop_sum;

  assign trig_hit    = !trig_en || (pc == trig_pc);
  assign below_limit = cycle < CNT_WIDTH'(CYCLE_LIMIT);
  assign at_last     = cycle == CNT_WIDTH'(CYCLE_LIMIT - 1);
  assign done        = cycle == CNT_WIDTH'(CYCLE_LIMIT);

  assign cap = ((state == ST_CAPTURE) || ((state == ST_ARMED) && trig_hit)) && below_limit;

  assign reg_ev = cap && ctrl_writeEnable && (ctrl_writeReg != 5'd0) && capture_mode[0];
  assign mem_ev = cap && wren && capture_mode[1];

  // Space is judged on occupancy before this cycle's pop, so a pop never
  // makes room for a same-cycle push.
  assign full     = count == CNT_W'(DEPTH);
  assign one_free = count == CNT_W'(DEPTH - 1);
  assign push_reg = reg_ev && !full;
  assign push_mem = mem_ev && !full && !(push_reg && one_free);

  // The first written slot holds the register event when there is one,
  // otherwise the memory event; the second slot is only ever the memory event.
  assign push0  = push_reg || push_mem;
  assign push1  = push_reg && push_mem;
  assign n_push = {1'b0, push0} + {1'b0, push1};
  assign n_drop = {1'b0, reg_ev && !push_reg} + {1'b0, mem_ev && !push_mem};
  assign pop    = rd_en && rd_valid;

  assign reg_addr  = ADDR_WIDTH'(ctrl_writeReg);
  assign wr_ptr_p1 = wr_ptr + PTR_W'(1);
  assign drop_sum  = {1'b0, drop_count} + 9'(n_drop);

  // Free-running cycle counter that stops at the limit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)            cycle <= '0;
    else if (below_limit) cycle <= cycle + CNT_WIDTH'(1);
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_ARMED;
    else       state <= state_next;
  end

  // FSM next-state: trigger arms capture, the last counted cycle ends it.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_ARMED: begin
        if (at_last)       state_next = ST_DONE;
        else if (trig_hit) state_next = ST_CAPTURE;
      end
      ST_CAPTURE: if (at_last) state_next = ST_DONE;
      ST_DONE:    state_next = ST_DONE;
      default:    state_next = ST_ARMED;
    endcase
  end

  // FIFO pointers, occupancy and drop bookkeeping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(n_push);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(n_push) - CNT_W'(pop);
      if (n_drop != 2'd0) begin
        overflow   <= 1'b1;
        drop_count <= (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];
      end
    end
  end

  // Entry storage; contents are don't-care until made visible by count.
  always_ff @(posedge clock) begin
    if (push0) begin
      mem_type[wr_ptr]  <= !push_reg;
      mem_cycle[wr_ptr] <= cycle;
      mem_pc[wr_ptr]    <= pc;
      mem_addr[wr_ptr]  <= push_reg ? reg_addr : address_dmem;
      mem_data[wr_ptr]  <= push_reg ? data_writeReg : data;
    end
    if (push1) begin
      mem_type[wr_ptr_p1]  <= 1'b1;
      mem_cycle[wr_ptr_p1] <= cycle;
      mem_pc[wr_ptr_p1]    <= pc;
      mem_addr[wr_ptr_p1]  <= address_dmem;
      mem_data[wr_ptr_p1]  <= data;
    end
  end

  // Show-ahead head outputs, forced to zero while empty.
  always_comb begin
    rd_valid = count != '0;
    rd_type  = 1'b0;
    rd_cycle = '0;
    rd_pc    = '0;
    rd_addr  = '0;
    rd_data  = '0;
    if (rd_valid) begin
      rd_type  = mem_type[rd_ptr];
      rd_cycle = mem_cycle[rd_ptr];
      rd_pc    = mem_pc[rd_ptr];
      rd_addr  = mem_addr[rd_ptr];
      rd_data  = mem_data[rd_ptr];
    end
  end

endmodule

// File: tb/tb_proc_trace_buffer.sv
// Directed, table-driven bench for proc_trace_buffer (DEPTH=4).
module tb_proc_trace_buffer;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int PW    = 12;
  localparam int AW    = 12;
  localparam int CW    = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          ctrl_writeEnable;
  logic [4:0]    ctrl_writeReg;
  logic [DW-1:0] data_writeReg;
  logic          wren;
  logic [AW-1:0] address_dmem;
  logic [DW-1:0] data;
  logic [PW-1:0] pc;
  logic [1:0]    capture_mode;
  logic          trig_en;
  logic [PW-1:0] trig_pc;
  logic          rd_en;
  logic          rd_valid;
  logic          rd_type;
  logic [CW-1:0] rd_cycle;
  logic [PW-1:0] rd_pc;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [2:0]    count;
  logic          overflow;
  logic [7:0]    drop_count;
  logic [CW-1:0] cycle;
  logic          done;

  int checks = 0;
  int errors = 0;

  proc_trace_buffer #(
    .DEPTH(DEPTH), .DATA_WIDTH(DW), .PC_WIDTH(PW), .ADDR_WIDTH(AW),
    .CNT_WIDTH(CW), .CYCLE_LIMIT(100)
  ) dut (
    .clock(clock), .reset(reset),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .wren(wren), .address_dmem(address_dmem),
    .data(data), .pc(pc), .capture_mode(capture_mode), .trig_en(trig_en),
    .trig_pc(trig_pc), .rd_en(rd_en), .rd_valid(rd_valid), .rd_type(rd_type),
    .rd_cycle(rd_cycle), .rd_pc(rd_pc), .rd_addr(rd_addr), .rd_data(rd_data),
    .count(count), .overflow(overflow), .drop_count(drop_count),
    .cycle(cycle), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    int we, wreg, wdata, wr, maddr, mdata, vpc, mode, rd;
    int e_valid, e_type, e_cyc, e_pc, e_addr, e_data, e_cnt, e_ovf, e_drop;
  } vec_t;

  function automatic vec_t mk(int we, int wreg, int wdata, int wr, int maddr,
                              int mdata, int vpc, int mode, int rd,
                              int e_valid, int e_type, int e_cyc, int e_pc,
                              int e_addr, int e_data, int e_cnt, int e_ovf,
                              int e_drop);
    vec_t v;
    v.we = we; v.wreg = wreg; v.wdata = wdata; v.wr = wr; v.maddr = maddr;
    v.mdata = mdata; v.vpc = vpc; v.mode = mode; v.rd = rd;
    v.e_valid = e_valid; v.e_type = e_type; v.e_cyc = e_cyc; v.e_pc = e_pc;
    v.e_addr = e_addr; v.e_data = e_data; v.e_cnt = e_cnt; v.e_ovf = e_ovf;
    v.e_drop = e_drop;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive_idle();
    ctrl_writeEnable = 1'b0; ctrl_writeReg = '0; data_writeReg = '0;
    wren = 1'b0; address_dmem = '0; data = '0; pc = '0; rd_en = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Drive one cycle of inputs from a negedge, let one edge pass, check at the next negedge.
  task automatic apply_vec(input string tag, input int idx, input vec_t v);
    ctrl_writeEnable = v.we[0];
    ctrl_writeReg    = v.wreg[4:0];
    data_writeReg    = v.wdata;
    wren             = v.wr[0];
    address_dmem     = v.maddr[AW-1:0];
    data             = v.mdata;
    pc               = v.vpc[PW-1:0];
    capture_mode     = v.mode[1:0];
    rd_en            = v.rd[0];
    @(posedge clock);
    @(negedge clock);
    chk({tag, ".rd_valid"},   idx, longint'(rd_valid),   longint'(v.e_valid));
    chk({tag, ".rd_type"},    idx, longint'(rd_type),    longint'(v.e_type));
    chk({tag, ".rd_cycle"},   idx, longint'(rd_cycle),   longint'(v.e_cyc));
    chk({tag, ".rd_pc"},      idx, longint'(rd_pc),      longint'(v.e_pc));
    chk({tag, ".rd_addr"},    idx, longint'(rd_addr),    longint'(v.e_addr));
    chk({tag, ".rd_data"},    idx, longint'(rd_data),    longint'(v.e_data));
    chk({tag, ".count"},      idx, longint'(count),      longint'(v.e_cnt));
    chk({tag, ".overflow"},   idx, longint'(overflow),   longint'(v.e_ovf));
    chk({tag, ".drop_count"}, idx, longint'(drop_count), longint'(v.e_drop));
  endtask

  vec_t tbl [33];
  vec_t seq [8];

  initial begin
    // Main table, applied from reset; vector i runs in cycle i.
    tbl[0]  = mk(0,0,0,      0,0,0,       0,1,0,  0,0,0,0,0,0,          0,0,0);
    tbl[1]  = mk(1,0,'h55,   0,0,0,       1,1,0,  0,0,0,0,0,0,          0,0,0);
    tbl[2]  = mk(0,0,0,      0,0,0,       0,1,0,  0,0,0,0,0,0,          0,0,0);
    tbl[3]  = mk(1,5,'h12,   0,0,0,       7,1,0,  1,0,3,7,5,'h12,       1,0,0);
    tbl[4]  = mk(1,3,'hAA,   1,'h40,'hBB, 9,3,0,  1,0,3,7,5,'h12,       3,0,0);
    tbl[5]  = mk(0,0,0,      0,0,0,       0,3,1,  1,0,4,9,3,'hAA,       2,0,0);
    tbl[6]  = mk(0,0,0,      0,0,0,       0,3,1,  1,1,4,9,'h40,'hBB,    1,0,0);
    tbl[7]  = mk(0,0,0,      0,0,0,       0,3,1,  0,0,0,0,0,0,          0,0,0);
    tbl[8]  = mk(0,0,0,      0,0,0,       0,3,1,  0,0,0,0,0,0,          0,0,0);
    tbl[9]  = mk(1,7,'h77,   1,'h12,'h34, 11,2,0, 1,1,9,11,'h12,'h34,   1,0,0);
    tbl[10] = mk(1,7,'h77,   1,'h13,'h35, 12,0,1, 0,0,0,0,0,0,          0,0,0);
    tbl[11] = mk(1,1,'h1,    0,0,0,       13,1,1, 1,0,11,13,1,1,        1,0,0);
    tbl[12] = mk(1,2,'h2,    0,0,0,       14,1,1, 1,0,12,14,2,2,        1,0,0);
    tbl[13] = mk(0,0,0,      0,0,0,       0,1,1,  0,0,0,0,0,0,          0,0,0);
    tbl[14] = mk(1,1,'h101,  0,0,0,       31,1,0, 1,0,14,31,1,'h101,    1,0,0);
    tbl[15] = mk(1,2,'h102,  0,0,0,       32,1,0, 1,0,14,31,1,'h101,    2,0,0);
    tbl[16] = mk(1,3,'h103,  0,0,0,       33,1,0, 1,0,14,31,1,'h101,    3,0,0);
    tbl[17] = mk(1,4,'h104,  0,0,0,       34,1,0, 1,0,14,31,1,'h101,    4,0,0);
    tbl[18] = mk(1,5,'h105,  0,0,0,       35,1,0, 1,0,14,31,1,'h101,    4,1,1);
    tbl[19] = mk(1,6,'h106,  0,0,0,       36,1,0, 1,0,14,31,1,'h101,    4,1,2);
    tbl[20] = mk(0,0,0,      0,0,0,       0,1,1,  1,0,15,32,2,'h102,    3,1,2);
    tbl[21] = mk(0,0,0,      0,0,0,       0,1,1,  1,0,16,33,3,'h103,    2,1,2);
    tbl[22] = mk(0,0,0,      0,0,0,       0,1,1,  1,0,17,34,4,'h104,    1,1,2);
    tbl[23] = mk(0,0,0,      0,0,0,       0,1,1,  0,0,0,0,0,0,          0,1,2);
    tbl[24] = mk(1,8,'h108,  0,0,0,       40,1,0, 1,0,24,40,8,'h108,    1,1,2);
    tbl[25] = mk(1,9,'h109,  0,0,0,       41,1,0, 1,0,24,40,8,'h108,    2,1,2);
    tbl[26] = mk(1,10,'h10A, 0,0,0,       42,1,0, 1,0,24,40,8,'h108,    3,1,2);
    tbl[27] = mk(1,11,'h10B, 1,'h50,'hC0, 43,3,0, 1,0,24,40,8,'h108,    4,1,3);
    tbl[28] = mk(1,12,'h10C, 1,'h51,'hC1, 44,3,0, 1,0,24,40,8,'h108,    4,1,5);
    tbl[29] = mk(0,0,0,      0,0,0,       0,3,1,  1,0,25,41,9,'h109,    3,1,5);
    tbl[30] = mk(0,0,0,      0,0,0,       0,3,1,  1,0,26,42,10,'h10A,   2,1,5);
    tbl[31] = mk(0,0,0,      0,0,0,       0,3,1,  1,0,27,43,11,'h10B,   1,1,5);
    tbl[32] = mk(0,0,0,      0,0,0,       0,3,1,  0,0,0,0,0,0,          0,1,5);

    capture_mode = 2'b01;
    trig_en = 1'b0;
    trig_pc = '0;
    drive_idle();
    reset = 1'b1;
    #1;
    chk("reset.rd_valid", 0, longint'(rd_valid), 0);
    chk("reset.count",    0, longint'(count), 0);
    chk("reset.cycle",    0, longint'(cycle), 0);
    chk("reset.done",     0, longint'(done), 0);
    chk("reset.overflow", 0, longint'(overflow), 0);
    do_reset();
    chk("reset.cycle_after", 0, longint'(cycle), 0);

    for (int i = 0; i < 33; i++) apply_vec("tbl", i, tbl[i]);

    // Trigger gating: pc 10 and 15 ignored, pc 20 starts capture, pc 21 continues.
    trig_en = 1'b1;
    trig_pc = 12'd20;
    do_reset();
    seq[0] = mk(1,1,'h11, 0,0,0, 10,1,0, 0,0,0,0,0,0,       0,0,0);
    seq[1] = mk(1,2,'h22, 0,0,0, 15,1,0, 0,0,0,0,0,0,       0,0,0);
    seq[2] = mk(1,3,'h33, 0,0,0, 20,1,0, 1,0,2,20,3,'h33,   1,0,0);
    seq[3] = mk(1,4,'h44, 0,0,0, 21,1,0, 1,0,2,20,3,'h33,   2,0,0);
    seq[4] = mk(0,0,0,    0,0,0, 22,1,1, 1,0,3,21,4,'h44,   1,0,0);
    for (int i = 0; i < 5; i++) apply_vec("trig", i, seq[i]);
    trig_en = 1'b0;

    // Cycle limit: capture ends at 100, buffered entries still drain.
    do_reset();
    drive_idle();
    capture_mode = 2'b01;
    repeat (98) begin
      @(posedge clock);
      @(negedge clock);
    end
    chk("lim.cycle98", 0, longint'(cycle), 98);
    apply_vec("lim", 0, mk(1,1,'h98, 0,0,0, 0,1,0, 1,0,98,0,1,'h98, 1,0,0));
    chk("lim.cycle99", 0, longint'(cycle), 99);
    chk("lim.done99",  0, longint'(done), 0);
    apply_vec("lim", 1, mk(1,2,'h99, 0,0,0, 0,1,0, 1,0,98,0,1,'h98, 2,0,0));
    chk("lim.cycle100", 0, longint'(cycle), 100);
    chk("lim.done100",  0, longint'(done), 1);
    apply_vec("lim", 2, mk(1,3,'hA0, 0,0,0, 0,1,0, 1,0,98,0,1,'h98, 2,0,0));
    chk("lim.cycle_hold", 0, longint'(cycle), 100);
    apply_vec("lim", 3, mk(0,0,0, 0,0,0, 0,1,1, 1,0,99,0,2,'h99, 1,0,0));
    apply_vec("lim", 4, mk(0,0,0, 0,0,0, 0,1,1, 0,0,0,0,0,0, 0,0,0));
    chk("lim.done_hold", 0, longint'(done), 1);

    // Asynchronous reset between edges with a partly full, overflowed FIFO.
    do_reset();
    for (int k = 0; k < 5; k++)
      apply_vec("ar", k, mk(1,k+1,k+1, 0,0,0, 0,1,0, 1,0,0,0,1,1,
                            (k < 4) ? k+1 : 4, (k == 4) ? 1 : 0, (k == 4) ? 1 : 0));
    apply_vec("ar", 5, mk(0,0,0, 0,0,0, 0,1,1, 1,0,1,0,2,2, 3,1,1));
    #2;
    reset = 1'b1;
    #1;
    chk("ar.rd_valid",   0, longint'(rd_valid), 0);
    chk("ar.count",      0, longint'(count), 0);
    chk("ar.overflow",   0, longint'(overflow), 0);
    chk("ar.drop_count", 0, longint'(drop_count), 0);
    chk("ar.cycle",      0, longint'(cycle), 0);
    chk("ar.done",       0, longint'(done), 0);
    chk("ar.rd_data",    0, longint'(rd_data), 0);
    @(negedge clock);
    reset = 1'b0;
    apply_vec("ar", 6, mk(1,6,'h66, 0,0,0, 5,1,0, 1,0,0,5,6,'h66, 1,0,0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/proc_trace_buffer.md
Name: proc_trace_buffer

Overview:
Synthesizable writeback/store trace capture unit for the pipelined processor. It timestamps register-file writes and data-memory writes with a free-running cycle count and buffers them in a parametrised FIFO for a host reader (VGA debug overlay or bench) to drain. Capture can be gated by a PC trigger and is terminated by a cycle limit. It is the hardware successor to the ad-hoc simulation monitors: filterable and depth/width-parametrised.

Parameters:
DEPTH, 16, FIFO entries (power of 2, >=2)
DATA_WIDTH, 32, data field width
PC_WIDTH, 12, PC field width
ADDR_WIDTH, 12, address field width; register numbers are zero-extended into it
CNT_WIDTH, 16, cycle counter / timestamp width
CYCLE_LIMIT, 100, cycle at which capture ends (< 2^CNT_WIDTH)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
ctrl_writeEnable  in  1  regfile write strobe (writeback stage)
ctrl_writeReg  in  5  destination register
data_writeReg  in  DATA_WIDTH  regfile write data
wren  in  1  dmem write strobe
address_dmem  in  ADDR_WIDTH  dmem write address
data  in  DATA_WIDTH  dmem write data
pc  in  PC_WIDTH  current PC (trigger compare and entry tag)
capture_mode  in  2  00 off, 01 reg only, 10 mem only, 11 both
trig_en  in  1  1: wait for pc==trig_pc before capturing
trig_pc  in  PC_WIDTH  trigger PC
rd_en  in  1  pop head entry
rd_valid  out  1  FIFO non-empty; head fields valid
rd_type  out  1  0 reg write, 1 mem write
rd_cycle  out  CNT_WIDTH  timestamp of head
rd_pc  out  PC_WIDTH  PC of head
rd_addr  out  ADDR_WIDTH  register number or dmem address
rd_data  out  DATA_WIDTH  written value
count  out  clog2(DEPTH)+1  occupancy
overflow  out  1  sticky, set on any dropped event
drop_count  out  8  dropped events, saturates at 255
cycle  out  CNT_WIDTH  current cycle count
done  out  1  cycle limit reached

Behaviour:
- Reset: all outputs 0; state ARMED; FIFO empty; pointers 0.
- cycle: +1 every clock from 0 while <CYCLE_LIMIT, then holds at CYCLE_LIMIT; done = (cycle==CYCLE_LIMIT), combinational from register.
- FSM: ARMED -> CAPTURE when trig_en==0 or pc==trig_pc; CAPTURE -> DONE when cycle==CYCLE_LIMIT-1 at the edge; ARMED -> DONE likewise; DONE held until reset.
- Capture enable cap = (state==CAPTURE or (state==ARMED and trigger hit)) and cycle<CYCLE_LIMIT. The trigger-hit cycle itself is captured.
- Event qualification: reg event = cap & ctrl_writeEnable & ctrl_writeReg!=0 & mode[0]; mem event = cap & wren & mode[1].
- Entry timestamp = cycle value in the event cycle; rd_pc = pc in that cycle.
- Dual event same cycle: reg entry written first, mem entry second (two pushes/cycle).
- Free space = DEPTH - count before any pop this cycle. A pop does not free a slot the same cycle.
- Space 0: all events dropped. Space 1 with dual event: reg kept, mem dropped.
- Each dropped event: overflow<=1, drop_count+1 (saturating). Pushes and drops count only qualified events.
- Read: show-ahead; rd_* reflect head whenever rd_valid. rd_en&rd_valid pops at the edge. rd_en while empty is ignored.
- Simultaneous push and pop: count += pushes - 1.
- rd_* fields are 0 when empty.
- Pointers wrap modulo DEPTH; count saturates naturally at DEPTH by the drop rule.
- capture_mode/trig changes take effect the same cycle; no restart of the FSM.
- Reading remains legal in DONE until empty.
- Async reset mid-operation discards contents and drop count; outputs go to 0 without waiting for a clock.

Test Plan:
- Reset, mode=01, trig_en=0; reg write r5=0x12 at cycle 3, pc=7 -> rd_valid=1, rd_type=0, rd_cycle=3, rd_pc=7, rd_addr=5, rd_data=0x12, count=1; write to r0 is not captured.
- mode=11, same cycle: reg r3=0xAA and dmem[0x40]=0xBB -> count=2; first pop gives type 0/addr 3; second gives type 1/addr 0x40/data 0xBB.
- DEPTH=4, six reg writes, no reads -> count=4, overflow=1, drop_count=2; pops return writes 1-4 in order. Then fill to 3, dual event -> reg kept, mem dropped, drop_count=3.
- trig_en=1, trig_pc=20; writes at pc 10 and 15 -> nothing captured; write at pc 20 captured; later writes at pc 21 captured.
- CYCLE_LIMIT=100: done=0 at cycle 99, done=1 when cycle=100; a write at cycle 100 is not captured; cycle holds at 100; buffered entries still drain.
- count=3 mid-capture, assert reset between edges -> rd_valid, count, overflow, cycle and done all 0 immediately. After release, capture restarts from cycle 0.
